// File: rtl/imm_encoder.sv
// Packs an immediate into instruction-word bit positions, checks it is representable,
// and queues {instr, addr, err} in a 2-entry FIFO. Optional macro IMM_ENC_ERR_COUNT_EN adds err_count.
module imm_encoder #(
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               ImmSrc,
  input  logic [ADDRESS_WIDTH-1:0] imm,
  input  logic [ADDRESS_WIDTH-1:0] base,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]    out_addr,
`ifdef IMM_ENC_ERR_COUNT_EN
  output logic                     err,
  output logic [7:0]               err_count
`else
  output logic                     err
`endif
);

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_R    = 3'b011,
    IMM_J    = 3'b100,
    IMM_U    = 3'b101,
    IMM_JALR = 3'b110,
    IMM_BAD  = 3'b111
  } imm_src_e;

  logic [ADDRESS_WIDTH-1:0] enc_instr;
  logic                     enc_err;

  // Sign-extension checks: upper bits must all be copies of the top encoded bit.
  logic sext_11, sext_12, sext_20;
  assign sext_11 = (&imm[31:11]) || !(|imm[31:11]);
  assign sext_12 = (&imm[31:12]) || !(|imm[31:12]);
  assign sext_20 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    enc_instr = base;
    enc_err   = 1'b0;
    case (imm_src_e'(ImmSrc))
      IMM_I, IMM_JALR: begin
        enc_instr[31:20] = imm[11:0];
        enc_err          = !sext_11;
      end
      IMM_S: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err          = !sext_11;
      end
      IMM_B: begin
        enc_instr[31]    = imm[12];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        enc_instr[7]     = imm[11];
        enc_err          = !sext_12 || imm[0];
      end
      IMM_R: begin
        enc_err = 1'b0;
      end
      IMM_J: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
        enc_err          = !sext_20 || imm[0];
      end
      IMM_U: begin
        enc_instr[31:12] = imm[31:12];
        enc_err          = |imm[11:0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  logic [ADDRESS_WIDTH-1:0] instr_mem [2];
  logic [ADDR_WIDTH-1:0]    addr_mem  [2];
  logic                     err_mem   [2];
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               count;
  logic [ADDR_WIDTH-1:0]    addr_cnt;
  logic [ADDRESS_WIDTH-1:0] last_instr;
  logic [ADDR_WIDTH-1:0]    last_addr;
  logic                     last_err;
  logic                     full, empty, push, pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // While empty the outputs show the last head entry, which is zero after reset.
  assign instr    = empty ? last_instr : instr_mem[rd_ptr];
  assign out_addr = empty ? last_addr  : addr_mem[rd_ptr];
  assign err      = empty ? last_err   : err_mem[rd_ptr];

  // NOTE: storage is not reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_instr;
      addr_mem[wr_ptr]  <= addr_cnt;
      err_mem[wr_ptr]   <= enc_err;
    end
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      addr_cnt   <= BASE_ADDR;
      last_instr <= '0;
      last_addr  <= '0;
      last_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= !wr_ptr;
        addr_cnt <= addr_cnt + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (!empty) begin
        last_instr <= instr_mem[rd_ptr];
        last_addr  <= addr_mem[rd_ptr];
        last_err   <= err_mem[rd_ptr];
      end
    end
  end

`ifdef IMM_ENC_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (push && enc_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against a queue-based reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  ImmSrc;
  logic [31:0] imm, base, instr, out_addr;
`ifdef IMM_ENC_ERR_COUNT_EN
  logic [7:0]  err_count;
  int          errc_m;
`endif

  logic        w_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
  logic [31:0] w_instr, w_addr;

  always #5 clk = ~clk;

  imm_encoder u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .out_addr  (out_addr),
`ifdef IMM_ENC_ERR_COUNT_EN
    .err       (err),
    .err_count (err_count)
`else
    .err       (err)
`endif
  );

  logic [7:0] w_err_count;
  imm_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_valid),
    .in_ready  (w_in_ready),
    .ImmSrc    (3'b011),
    .imm       (32'h0),
    .base      (32'h0000_0033),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .instr     (w_instr),
    .out_addr  (w_addr),
`ifdef IMM_ENC_ERR_COUNT_EN
    .err       (w_err),
    .err_count (w_err_count)
`else
    .err       (w_err)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      q[$];
  entry_t      last;
  logic [31:0] addr_m;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: legality as signed ranges / alignment, encoding as field concatenation.
  function automatic entry_t model(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs);
    entry_t e;
    int     si;
    si      = int'(im);
    e.addr  = '0;
    e.instr = bs;
    e.err   = 1'b0;
    case (src)
      3'd0, 3'd6: begin
        e.instr = {im[11:0], bs[19:0]};
        e.err   = !(si >= -2048 && si <= 2047);
      end
      3'd1: begin
        e.instr = {im[11:5], bs[24:12], im[4:0], bs[6:0]};
        e.err   = !(si >= -2048 && si <= 2047);
      end
      3'd2: begin
        e.instr = {im[12], im[10:5], bs[24:12], im[4:1], im[11], bs[6:0]};
        e.err   = !(si >= -4096 && si <= 4095 && (si % 2 == 0));
      end
      3'd3: e.instr = bs;
      3'd4: begin
        e.instr = {im[20], im[10:1], im[11], im[19:12], bs[11:0]};
        e.err   = !(si >= -(1 << 20) && si <= (1 << 20) - 1 && (si % 2 == 0));
      end
      3'd5: begin
        e.instr = {im[31:12], bs[11:0]};
        e.err   = (im % 4096) != 0;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: drive at negedge, compare outputs to the model, then advance the model.
  task automatic cycle(input logic v, input logic [2:0] src, input logic [31:0] im,
                       input logic [31:0] bs, input logic rdy);
    entry_t e;
    logic   acc, pp;
    @(negedge clk);
    in_valid = v; ImmSrc = src; imm = im; base = bs; out_ready = rdy;
    #1;
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("instr", instr, q[0].instr);
      check("out_addr", out_addr, q[0].addr);
      check("err", err, q[0].err);
    end else begin
      check("hold_instr", instr, last.instr);
      check("hold_addr", out_addr, last.addr);
      check("hold_err", err, last.err);
    end
`ifdef IMM_ENC_ERR_COUNT_EN
    check("err_count", err_count, errc_m);
`endif
    acc = v && (q.size() < 2);
    pp  = rdy && (q.size() > 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (pp) last = q.pop_front();
    if (acc) begin
      e      = model(src, im, bs);
      e.addr = addr_m;
      addr_m = addr_m + 32'd4;
      q.push_back(e);
`ifdef IMM_ENC_ERR_COUNT_EN
      if (e.err && errc_m < 255) errc_m++;
`endif
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] ei, input logic [31:0] ea, input logic ee);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_instr"}, instr, ei);
    check({tag, "_addr"}, out_addr, ea);
    check({tag, "_err"}, err, ee);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic directed(input string tag, input logic [2:0] src, input logic [31:0] im,
                          input logic [31:0] bs, input logic [31:0] ei, input logic ee);
    logic [31:0] a;
    a = addr_m;
    cycle(1'b1, src, im, bs, 1'b0);
    peek(tag, ei, a, ee);
    drain();
  endtask

  // Asserts reset between clock edges and checks the outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    q.delete();
    last   = '{instr: 32'h0, addr: 32'h0, err: 1'b0};
    addr_m = 32'h0;
`ifdef IMM_ENC_ERR_COUNT_EN
    errc_m = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  src;
    logic [31:0] im;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ImmSrc = 3'd0; imm = '0; base = '0;
    w_valid = 1'b0; w_out_ready = 1'b0;
    do_reset();

    // Wrapping address counter on the second instance.
    @(negedge clk); w_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1; w_valid = 1'b0;
    @(negedge clk); #1;
    check("wrap_full", w_in_ready, 1'b0);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_out_ready = 1'b1;
    @(posedge clk); #1; w_out_ready = 1'b0;
    @(negedge clk); #1;
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_valid", w_out_valid, 1'b1);

    directed("i_neg1",   3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    directed("i_ovf",    3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    directed("b_ok",     3'd2, 32'h0000_0010, 32'h0000_0063, 32'h0000_0863, 1'b0);
    directed("b_odd",    3'd2, 32'h0000_0011, 32'h0000_0063, 32'h0000_0863, 1'b1);
    directed("u_ok",     3'd5, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0);
    directed("j_ok",     3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    directed("u_low",    3'd5, 32'h1234_5001, 32'h0000_00B7, 32'h1234_50B7, 1'b1);
    directed("illegal",  3'd7, 32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    directed("r_pass",   3'd3, 32'hFFFF_FFFF, 32'h00B5_0533, 32'h00B5_0533, 1'b0);
    directed("s_max",    3'd1, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0);
    directed("jalr_min", 3'd6, 32'hFFFF_F800, 32'h0000_0067, 32'h8000_0067, 1'b0);
    directed("b_min",    3'd2, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0);

    // Backpressure: third request stalls until a slot frees, then push and pop overlap.
    do_reset();
    cycle(1'b1, 3'd0, 32'd1, 32'h13, 1'b0);
    cycle(1'b1, 3'd0, 32'd2, 32'h13, 1'b0);
    cycle(1'b1, 3'd0, 32'd3, 32'h13, 1'b0);
    peek("bp_head", 32'h0010_0013, 32'h0, 1'b0);
    cycle(1'b1, 3'd0, 32'd3, 32'h13, 1'b1);
    cycle(1'b1, 3'd0, 32'd3, 32'h13, 1'b1);
    peek("bp_third", 32'h0030_0013, 32'h8, 1'b0);
    drain();

    // Reset while two entries are queued.
    cycle(1'b1, 3'd5, 32'hABCD_E000, 32'h37, 1'b0);
    cycle(1'b1, 3'd5, 32'h1111_1000, 32'h37, 1'b0);
    do_reset();
    directed("post_rst", 3'd0, 32'h0000_0005, 32'h13, 32'h0050_0013, 1'b0);

    for (int n = 0; n < 600; n++) begin
      src = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       im = $urandom;
        1:       im = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: im = $urandom & 32'hFFFF_F000;
      endcase
      cycle(1'($urandom_range(0, 1)), src, im, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();

`ifdef IMM_ENC_ERR_COUNT_EN
    do_reset();
    for (int n = 0; n < 300; n++) cycle(1'b1, 3'd7, 32'd0, 32'd0, 1'b1);
    check("err_count_sat", err_count, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate into the instruction-word bit positions selected by ImmSrc.
- Merges the packed bits with a caller-supplied base word that carries opcode, rd, rs1, rs2 and funct fields.
- Checks the immediate is representable, buffers results in a 2-entry FIFO, and tags each word with a sequential instruction-memory address.
- Sits between the boot/program loader and instruction-memory write port.

Parameters:
ADDRESS_WIDTH, 32, instruction/immediate width (fixed 32; parameter kept for consistency).
ADDR_WIDTH, 32, width of the out_addr address tag.
BASE_ADDR, 0, address tagged on the first word after reset.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
ImmSrc  input  3  immediate format, same encoding as the immediate generator.
imm  input  32  immediate value to encode (two's complement).
base  input  32  instruction word; bits at immediate positions are ignored and overwritten.
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer pops the head when out_valid && out_ready.
instr  output  32  encoded instruction at FIFO head.
out_addr  output  ADDR_WIDTH  address tag of head entry.
err  output  1  head entry had an unrepresentable immediate or an illegal ImmSrc.

Behaviour:
- Encoding; all bits not listed come from base.
  - 000 I and 110 JALR: [31:20]=imm[11:0]. Legal iff imm[31:11] are all equal.
  - 001 S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same legality rule as I.
  - 010 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Legal iff imm[31:12] are all equal and imm[0]=0.
  - 011 R: instr=base; imm ignored; always legal.
  - 100 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Legal iff imm[31:20] are all equal and imm[0]=0.
  - 101 U: [31:12]=imm[31:12]. Legal iff imm[11:0]=0.
  - 111: illegal; instr=base, err=1.
- Illegal entries are still pushed, with the encoded bits (truncated) and err=1.
- FIFO: 2 entries, each holding {instr, addr, err}; head/tail pointers plus a count.
  - in_ready = !full && !rst.
  - Push on accept; the entry is visible at the head the cycle after acceptance (1-cycle latency).
  - No same-cycle pass-through.
  - out_valid = !empty; instr/out_addr/err are driven from the head entry and held stable while out_valid && !out_ready.
  - Simultaneous push and pop with count=1: count stays 1, order preserved.
  - When full, in_ready=0 and a pop frees one slot for the next cycle.
  - When empty, out_valid=0 and instr/out_addr/err hold their last values (0 after reset).
- Address counter: starts at BASE_ADDR; each accepted request is tagged with the current value, then the counter increments by 4 modulo 2^ADDR_WIDTH (wraps silently).
- Reset (async, any time, including mid-transfer):
  - FIFO emptied; address counter = BASE_ADDR.
  - out_valid=0, instr=0, out_addr=0, err=0, in_ready=0 while rst is high; in_ready=1 the first cycle after rst falls.

Optional Feature:
- Macro: IMM_ENC_ERR_COUNT_EN.
- Defined:
  - Adds output port err_count [7:0]: count of accepted requests with err=1, saturating at 255.
  - Reset to 0.
  - Increments in the acceptance cycle, visible the next cycle.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- I-type: imm=0xFFFFFFFF, base=0x00000013 -> instr=0xFFF00013, err=0, out_addr=0x0, one cycle after accept. Then imm=0x00000800 -> err=1.
- B-type: imm=0x00000010, base=0x00000063 -> instr=0x00000863, err=0. Then imm=0x00000011 -> err=1 (odd).
- U/J: U imm=0x12345000, base=0x000000B7 -> 0x123450B7. J imm=0x00000800, base=0x0000006F -> 0x0010006F. U imm=0x12345001 -> err=1.
- Backpressure: out_ready=0, offer 3 requests back-to-back -> in_ready drops after 2. Raise out_ready -> three outputs in order with out_addr 0x0, 0x4, 0x8; simultaneous push/pop keeps order.
- Illegal/wrap: ImmSrc=111 -> instr=base, err=1. With BASE_ADDR=0xFFFFFFFC, two pushes -> out_addr 0xFFFFFFFC then 0x0. With IMM_ENC_ERR_COUNT_EN, 300 errored pushes -> err_count=255.
- Reset mid-op: FIFO holding 2 entries, assert rst asynchronously -> out_valid=0, instr=0 immediately. After release, the next request is tagged out_addr=BASE_ADDR.
